// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: assembles big-endian words from a byte stream.
// Optional trailer checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK = 3'd5
`endif
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CHK;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_idx;
    logic [31:0]         r_shift;
    logic [31:0]         r_n;
    logic                r_byte_ready;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_cpu_hold;
    logic                r_done;
    logic                r_err;
    logic [ADDR_WIDTH:0] r_word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]         r_sum;
`endif

    logic                w_accept;
    logic                w_last_byte;
    logic                w_start_ok;
    logic                w_hdr_zero;
    logic                w_hdr_over;
    logic                w_last_word;
    logic [31:0]         w_word;
    logic [31:0]         w_count_inc;
    logic [31:0]         w_wr_addr;

    function automatic logic f_is_rx(input state_t s);
        case (s)
            S_HDR, S_DATA: f_is_rx = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:         f_is_rx = 1'b1;
`endif
            default:       f_is_rx = 1'b0;
        endcase
    endfunction

    function automatic logic f_is_hold(input state_t s);
        case (s)
            S_HDR, S_DATA, S_WRITE: f_is_hold = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:                  f_is_hold = 1'b1;
`endif
            default:                f_is_hold = 1'b0;
        endcase
    endfunction

    assign w_accept    = byte_valid && f_is_rx(r_state);
    assign w_last_byte = w_accept && (r_idx == 2'd3);
    assign w_word      = {r_shift[23:0], byte_in};
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_hdr_zero  = (w_word == 32'd0);
    assign w_hdr_over  = ({1'b0, w_word} > DEPTH);
    assign w_count_inc = 32'(r_word_count) + 32'd1;
    assign w_last_word = (w_count_inc == r_n);
    assign w_wr_addr   = BASE_ADDR + (32'(r_word_count) << 2'd2);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_HDR;
                else       w_next_state = r_state;
            end
            S_HDR: begin
                if (w_last_byte) begin
                    if (w_hdr_zero)      w_next_state = S_AFTER_DATA;
                    else if (w_hdr_over) w_next_state = S_DONE;
                    else                 w_next_state = S_DATA;
                end else begin
                    w_next_state = r_state;
                end
            end
            S_DATA: begin
                if (w_last_byte) w_next_state = S_WRITE;
                else             w_next_state = r_state;
            end
            S_WRITE: begin
                if (w_last_word) w_next_state = S_AFTER_DATA;
                else             w_next_state = S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_last_byte) w_next_state = S_DONE;
                else             w_next_state = r_state;
            end
`endif
            S_DONE: begin
                if (start) w_next_state = S_HDR;
                else       w_next_state = r_state;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; status outputs follow the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_cpu_hold   <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= {(ADDR_WIDTH+1){1'b0}};
            r_idx        <= 2'd0;
            r_shift      <= 32'd0;
            r_n          <= 32'd0;
        end else begin
            r_byte_ready <= f_is_rx(w_next_state);
            r_cpu_hold   <= f_is_hold(w_next_state);
            r_mem_we     <= (w_next_state == S_WRITE);
            r_done       <= (w_next_state == S_DONE);
            if (w_start_ok) begin
                r_idx        <= 2'd0;
                r_word_count <= {(ADDR_WIDTH+1){1'b0}};
                r_err        <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_shift <= w_word;
                    r_idx   <= r_idx + 2'd1;
                end
                if ((r_state == S_HDR) && w_last_byte) begin
                    r_n <= w_word;
                    if (w_hdr_over) r_err <= 1'b1;
                end
                if ((r_state == S_DATA) && w_last_byte) begin
                    r_mem_addr  <= w_wr_addr;
                    r_mem_wdata <= w_word;
                end
                if (r_state == S_WRITE) begin
                    r_word_count <= w_count_inc[ADDR_WIDTH:0];
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                if ((r_state == S_CHK) && w_last_byte && (w_word != r_sum)) begin
                    r_err <= 1'b1;
                end
`endif
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running sum of every written word, compared against the trailer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= 32'd0;
        end else if (w_start_ok) begin
            r_sum <= 32'd0;
        end else if (r_state == S_WRITE) begin
            r_sum <= r_sum + r_mem_wdata;
        end else begin
            r_sum <= r_sum;
        end
    end
`endif

    assign byte_ready = r_byte_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load scenarios plus reset/boundary sequences.
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;

    logic          br0, we0, hold0, done0, err0;
    logic [31:0]   addr0, wdata0;
    logic [AW:0]   wc0;
    logic          br1, we1, hold1, done1, err1;
    logic [31:0]   addr1, wdata1;
    logic [AW:0]   wc1;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(br0), .mem_we(we0),
        .mem_addr(addr0), .mem_wdata(wdata0), .cpu_hold(hold0),
        .done(done0), .err(err0), .word_count(wc0)
    );

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h100)) dut1 (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(br1), .mem_we(we1),
        .mem_addr(addr1), .mem_wdata(wdata1), .cpu_hold(hold1),
        .done(done1), .err(err1), .word_count(wc1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hdr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        bubble;
        logic        mid_start;
        logic        cs_bad;
        logic [31:0] exp_writes;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[8];
    int          n_tests = 0;
    int          n_fail  = 0;
    string       g_tag   = "init";
    logic [31:0] q_addr0[$];
    logic [31:0] q_data0[$];
    logic [31:0] q_addr1[$];

    // Write log, sampled mid-cycle
    always @(negedge clk) begin
        if (we0) begin
            q_addr0.push_back(addr0);
            q_data0.push_back(wdata0);
        end
        if (we1) q_addr1.push_back(addr1);
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %h required %h", g_tag, name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %b required %b", g_tag, name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bubble);
        int cnt;
        if (bubble) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        cnt        = 0;
        while (br0 !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        if (br0 !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s/accept_timeout: byte_ready %b required 1", g_tag, br0);
            byte_valid = 1'b0;
        end else begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic bubble);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], bubble);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_idle();
        chk1("rst_ready", br0, 1'b0);
        chk1("rst_we", we0, 1'b0);
        chk32("rst_addr", addr0, 32'h0);
        chk32("rst_wdata", wdata0, 32'h0);
        chk1("rst_hold", hold0, 1'b0);
        chk1("rst_done", done0, 1'b0);
        chk1("rst_err", err0, 1'b0);
        chk32("rst_wc", 32'(wc0), 32'd0);
        chk32("rst_addr_b100", addr1, 32'h0);
    endtask

    task automatic run_load(input vec_t v, input int idx);
        logic [31:0] words[2];
        logic [31:0] sum;
        logic        exp_err;
        int          nw;
        g_tag    = $sformatf("v%0d", idx);
        words[0] = v.w0;
        words[1] = v.w1;
        sum      = 32'd0;
        q_addr0.delete();
        q_data0.delete();
        q_addr1.delete();
        pulse_start();
        chk1("start_ready", br0, 1'b1);
        chk1("start_hold", hold0, 1'b1);
        chk1("start_done_clr", done0, 1'b0);
        chk32("start_wc_clr", 32'(wc0), 32'd0);
        send_word(v.hdr, v.bubble);
        nw = (v.hdr <= 32'd1024) ? int'(v.hdr) : 0;
        for (int k = 0; k < nw && k < 2; k++) begin
            if (v.mid_start && k == 1) begin
                start = 1'b1;
                @(negedge clk);
                @(negedge clk);
                start = 1'b0;
                chk32("ignored_start_wc", 32'(wc0), 32'd1);
                chk1("ignored_start_hold", hold0, 1'b1);
            end
            send_word(words[k], v.bubble);
            chk1("we_latency", we0, 1'b1);
            chk32("wr_addr", addr0, 32'(4 * k));
            chk32("wr_data", wdata0, words[k]);
            chk32("wr_addr_b100", addr1, 32'h100 + 32'(4 * k));
            chk1("ready_in_write", br0, 1'b0);
            sum = sum + words[k];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (v.hdr <= 32'd1024) send_word(v.cs_bad ? 32'h0 : sum, 1'b0);
        exp_err = v.exp_err | v.cs_bad;
`else
        if (nw > 0) @(negedge clk);
        exp_err = v.exp_err;
`endif
        chk1("done", done0, 1'b1);
        chk1("hold_released", hold0, 1'b0);
        chk1("ready_low", br0, 1'b0);
        chk1("err", err0, exp_err);
        chk32("word_count", 32'(wc0), v.exp_writes);
        chk32("n_writes", 32'(q_addr0.size()), v.exp_writes);
        chk32("n_writes_b100", 32'(q_addr1.size()), v.exp_writes);
        for (int i = 0; i < nw && i < 2 && i < q_addr0.size() && i < q_addr1.size(); i++) begin
            chk32("log_addr", q_addr0[i], 32'(4 * i));
            chk32("log_data", q_data0[i], words[i]);
            chk32("log_addr_b100", q_addr1[i], 32'h100 + 32'(4 * i));
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        //           hdr           w0            w1            bub   mid   csbad  writes  err
        vecs[0] = '{32'd2,        32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0, 1'b0, 32'd2, 1'b0};
        vecs[1] = '{32'd2,        32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0, 1'b0, 32'd2, 1'b0};
        vecs[2] = '{32'd0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
        vecs[3] = '{32'h401,      32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'd0, 1'b1};
        vecs[4] = '{32'd1,        32'hCAFEF00D, 32'h0,        1'b1, 1'b0, 1'b0, 32'd1, 1'b0};
        vecs[5] = '{32'd2,        32'h11223344, 32'h8899AABB, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'd0, 1'b1};
        vecs[7] = '{32'd2,        32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0, 1'b1, 32'd2, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        g_tag = "reset";
        check_idle();

        for (int i = 0; i < 8; i++) run_load(vecs[i], i);

        // Reset two bytes into the first data word
        g_tag = "rst_mid";
        pulse_start();
        send_word(32'd2, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        q_addr0.delete();
        q_data0.delete();
        q_addr1.delete();
        do_reset();
        check_idle();
        repeat (6) @(negedge clk);
        chk32("no_write_after_reset", 32'(q_addr0.size()), 32'd0);
        chk1("still_idle_ready", br0, 1'b0);
        run_load(vecs[0], 8);

        // Largest legal header is accepted and proceeds to data
        g_tag = "n_depth";
        pulse_start();
        send_word(32'h400, 1'b0);
        chk1("depth_done", done0, 1'b0);
        chk1("depth_err", err0, 1'b0);
        chk1("depth_ready", br0, 1'b1);
        chk1("depth_hold", hold0, 1'b1);
        do_reset();
        check_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
